// File: rtl/battlefield_pkg.sv
// Shared types and constants for the battlefield layer controller: player state,
// update FSM states and sprite/background geometry.
package battlefield_pkg;

  localparam int SPR_W = 32;
  localparam int SPR_H = 48;
  localparam int BG_W  = 320;
  localparam logic [3:0] TRANSP_IDX  = 4'd0;
  localparam logic [9:0] COMMIT_LINE = 10'd480;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [2:0] frame;
    logic       flip;
    logic       en;
  } player_state_t;

  localparam player_state_t PLAYER_RST = '{x: 10'd0, y: 10'd0, frame: 3'd0, flip: 1'b0, en: 1'b0};

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PEND = 1'b1
  } upd_state_e;

  // Frames are stacked vertically; SPR_W is 32, so the column occupies the low 5 address bits.
  function automatic logic [13:0] spr_addr_calc(input logic [2:0] frame,
                                                input logic [5:0] row,
                                                input logic [4:0] col);
    logic [8:0] line_v;
    line_v = 9'(frame) * 9'(SPR_H) + 9'(row);
    return {line_v, col};
  endfunction

endpackage

// File: rtl/sprite_hit_calc.sv
// Combinational hit test and sheet address for one player sprite at the current pixel.
module sprite_hit_calc
  import battlefield_pkg::*;
(
  input  player_state_t ps,
  input  logic [9:0]    draw_x,
  input  logic [9:0]    draw_y,
  output logic          hit,
  output logic [13:0]   addr
);

  logic       in_x_s;
  logic       in_y_s;
  logic [4:0] col_raw_s;
  logic [4:0] col_s;
  logic [5:0] row_s;

  // Bounds are compared in 11 bits so a sprite near X=1023 cannot wrap onto column 0.
  always_comb begin
    in_x_s    = ({1'b0, draw_x} >= {1'b0, ps.x}) &&
                ({1'b0, draw_x} <  ({1'b0, ps.x} + 11'(SPR_W)));
    in_y_s    = ({1'b0, draw_y} >= {1'b0, ps.y}) &&
                ({1'b0, draw_y} <  ({1'b0, ps.y} + 11'(SPR_H)));
    hit       = ps.en && in_x_s && in_y_s;
    col_raw_s = 5'(draw_x - ps.x);
    row_s     = 6'(draw_y - ps.y);
    if (ps.flip) begin
      col_s = 5'(SPR_W - 1) - col_raw_s;
    end else begin
      col_s = col_raw_s;
    end
    addr = spr_addr_calc(ps.frame, row_s, col_s);
  end

endmodule

// File: rtl/battlefield_layer_ctrl.sv
// Per-pixel sprite/background scheduler: shares one sprite ROM between two players,
// composites over the 2x-stretched background and commits player updates at frame boundaries.
module battlefield_layer_ctrl
  import battlefield_pkg::*;
(
  input  logic        vga_clk,
  input  logic        Reset,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic        blank,
  input  logic        upd_valid,
  output logic        upd_ready,
  input  logic [9:0]  p1_x,
  input  logic [9:0]  p1_y,
  input  logic [9:0]  p2_x,
  input  logic [9:0]  p2_y,
  input  logic [2:0]  p1_frame,
  input  logic [2:0]  p2_frame,
  input  logic        p1_flip,
  input  logic        p2_flip,
  input  logic        p1_en,
  input  logic        p2_en,
  input  logic        p2_on_top,
  output logic [16:0] bg_addr,
  output logic [13:0] spr_addr,
  input  logic [3:0]  bg_q,
  input  logic [3:0]  spr_q,
  output logic [3:0]  pix_index,
  output logic        pix_layer,
  output logic        pix_valid,
  output logic        frame_tick
);

  upd_state_e    state_r, state_nxt_s;
  player_state_t pend_p1_r, pend_p2_r, act_p1_r, act_p2_r;
  player_state_t in_p1_s, in_p2_s;
  logic          pend_prio_r, act_prio_r;
  logic          commit_s, accept_s, copy_s;
  logic          p1_hit_s, p2_hit_s, sel_any_s, sel_p2_s;
  logic [13:0]   p1_addr_s, p2_addr_s;
  logic [3:0]    comp_index_s;
  logic          comp_layer_s;
  logic [3:0]    pix_index_r;
  logic          pix_layer_r, pix_valid_r, frame_tick_r;

  assign in_p1_s = '{x: p1_x, y: p1_y, frame: p1_frame, flip: p1_flip, en: p1_en};
  assign in_p2_s = '{x: p2_x, y: p2_y, frame: p2_frame, flip: p2_flip, en: p2_en};

  assign commit_s  = (DrawY == COMMIT_LINE) && (DrawX == 10'd0);
  assign bg_addr   = 17'(DrawX[9:1]) + 17'(DrawY[9:1]) * 17'(BG_W);
  assign upd_ready = (state_r == IDLE);

  sprite_hit_calc u_hit_p1 (.ps(act_p1_r), .draw_x(DrawX), .draw_y(DrawY), .hit(p1_hit_s), .addr(p1_addr_s));
  sprite_hit_calc u_hit_p2 (.ps(act_p2_r), .draw_x(DrawX), .draw_y(DrawY), .hit(p2_hit_s), .addr(p2_addr_s));

  // Update FSM next state: accept in IDLE, commit pending state at the commit point in PEND.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    copy_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (upd_valid) begin
          accept_s    = 1'b1;
          state_nxt_s = PEND;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      PEND: begin
        if (commit_s) begin
          copy_s      = 1'b1;
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = PEND;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Sprite selection and compositing; the lower-priority player is never fetched under the top one.
  always_comb begin
    sel_any_s = p1_hit_s || p2_hit_s;
    sel_p2_s  = p2_hit_s && (act_prio_r || !p1_hit_s);
    if (sel_p2_s) begin
      spr_addr = p2_addr_s;
    end else if (sel_any_s) begin
      spr_addr = p1_addr_s;
    end else begin
      spr_addr = 14'd0;
    end
    if (sel_any_s && (spr_q != TRANSP_IDX)) begin
      comp_index_s = spr_q;
      comp_layer_s = 1'b1;
    end else begin
      comp_index_s = bg_q;
      comp_layer_s = 1'b0;
    end
  end

  // FSM state plus pending/active player registers.
  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      state_r     <= IDLE;
      pend_p1_r   <= PLAYER_RST;
      pend_p2_r   <= PLAYER_RST;
      pend_prio_r <= 1'b0;
      act_p1_r    <= PLAYER_RST;
      act_p2_r    <= PLAYER_RST;
      act_prio_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (accept_s) begin
        pend_p1_r   <= in_p1_s;
        pend_p2_r   <= in_p2_s;
        pend_prio_r <= p2_on_top;
      end
      if (copy_s) begin
        act_p1_r   <= pend_p1_r;
        act_p2_r   <= pend_p2_r;
        act_prio_r <= pend_prio_r;
      end
    end
  end

  // Pixel output register; lags DrawX/DrawY by one cycle.
  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      pix_index_r  <= 4'd0;
      pix_layer_r  <= 1'b0;
      pix_valid_r  <= 1'b0;
      frame_tick_r <= 1'b0;
    end else begin
      pix_index_r  <= comp_index_s;
      pix_layer_r  <= comp_layer_s;
      pix_valid_r  <= blank;
      frame_tick_r <= commit_s;
    end
  end

  assign pix_index  = pix_index_r;
  assign pix_layer  = pix_layer_r;
  assign pix_valid  = pix_valid_r;
  assign frame_tick = frame_tick_r;

endmodule

// File: tb/tb_battlefield_layer_ctrl.sv
// Directed bench for battlefield_layer_ctrl: pixel outputs are checked through a scoreboard
// queue, addresses and handshake signals are checked directly.
module tb_battlefield_layer_ctrl;

  logic        vga_clk = 1'b0;
  logic        Reset;
  logic [9:0]  DrawX, DrawY;
  logic        blank, upd_valid, upd_ready;
  logic [9:0]  p1_x, p1_y, p2_x, p2_y;
  logic [2:0]  p1_frame, p2_frame;
  logic        p1_flip, p2_flip, p1_en, p2_en, p2_on_top;
  logic [16:0] bg_addr;
  logic [13:0] spr_addr;
  logic [3:0]  bg_q, spr_q, pix_index;
  logic        pix_layer, pix_valid, frame_tick;

  typedef struct {
    logic [3:0] idx;
    logic       layer;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  battlefield_layer_ctrl dut (
    .vga_clk(vga_clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .upd_valid(upd_valid), .upd_ready(upd_ready),
    .p1_x(p1_x), .p1_y(p1_y), .p2_x(p2_x), .p2_y(p2_y),
    .p1_frame(p1_frame), .p2_frame(p2_frame), .p1_flip(p1_flip), .p2_flip(p2_flip),
    .p1_en(p1_en), .p2_en(p2_en), .p2_on_top(p2_on_top),
    .bg_addr(bg_addr), .spr_addr(spr_addr), .bg_q(bg_q), .spr_q(spr_q),
    .pix_index(pix_index), .pix_layer(pix_layer), .pix_valid(pix_valid), .frame_tick(frame_tick)
  );

  always #5 vga_clk = ~vga_clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp_v);
    end
  endtask

  // Monitor: every valid output pixel is matched against the oldest queued expectation.
  always @(negedge vga_clk) begin
    if (pix_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pix_unexpected: got index %0d layer %0d, expected no valid pixel", pix_index, pix_layer);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("pix_index_layer", {27'd0, pix_index, pix_layer}, {27'd0, e.idx, e.layer});
      end
    end
  end

  task automatic px(input logic [9:0] x, input logic [9:0] y, input logic b,
                    input logic [3:0] bq, input logic [3:0] sq,
                    input logic [3:0] ei, input logic el);
    @(posedge vga_clk);
    #1;
    DrawX = x; DrawY = y; blank = b; bg_q = bq; spr_q = sq;
    if (b) sb.push_back('{idx: ei, layer: el});
    #1;
  endtask

  task automatic set_players(input logic [9:0] ax, input logic [9:0] ay, input logic [2:0] af,
                             input logic afl, input logic ae,
                             input logic [9:0] bx, input logic [9:0] by, input logic [2:0] bf,
                             input logic bfl, input logic be, input logic top);
    p1_x = ax; p1_y = ay; p1_frame = af; p1_flip = afl; p1_en = ae;
    p2_x = bx; p2_y = by; p2_frame = bf; p2_flip = bfl; p2_en = be;
    p2_on_top = top;
  endtask

  task automatic update(input logic [9:0] ax, input logic [9:0] ay, input logic [2:0] af,
                        input logic afl, input logic ae,
                        input logic [9:0] bx, input logic [9:0] by, input logic [2:0] bf,
                        input logic bfl, input logic be, input logic top);
    px(10'd300, 10'd200, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
    set_players(ax, ay, af, afl, ae, bx, by, bf, bfl, be, top);
    upd_valid = 1'b1;
    chk("ready_before_update", {31'd0, upd_ready}, 32'd1);
    px(10'd301, 10'd200, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
    upd_valid = 1'b0;
    chk("ready_in_pend", {31'd0, upd_ready}, 32'd0);
  endtask

  task automatic commit();
    px(10'd0, 10'd480, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
    px(10'd1, 10'd480, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
    chk("frame_tick_pulse", {31'd0, frame_tick}, 32'd1);
    px(10'd2, 10'd480, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
    chk("frame_tick_clear", {31'd0, frame_tick}, 32'd0);
    chk("ready_after_commit", {31'd0, upd_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1; DrawX = 10'd0; DrawY = 10'd0; blank = 1'b0; upd_valid = 1'b0;
    bg_q = 4'd0; spr_q = 4'd0;
    set_players(10'd0, 10'd0, 3'd0, 1'b0, 1'b0, 10'd0, 10'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge vga_clk);
    #1;
    chk("rst_pix_index", {28'd0, pix_index}, 32'd0);
    chk("rst_pix_layer", {31'd0, pix_layer}, 32'd0);
    chk("rst_pix_valid", {31'd0, pix_valid}, 32'd0);
    chk("rst_frame_tick", {31'd0, frame_tick}, 32'd0);
    chk("rst_upd_ready", {31'd0, upd_ready}, 32'd1);
    Reset = 1'b0;

    // Background only
    px(10'd100, 10'd50, 1'b1, 4'd5, 4'd0, 4'd5, 1'b0);
    chk("bg_addr_100_50", {15'd0, bg_addr}, 32'd8050);
    chk("spr_addr_no_sprite", {18'd0, spr_addr}, 32'd0);
    px(10'd101, 10'd50, 1'b1, 4'd8, 4'd3, 4'd8, 1'b0);

    // P1 update mid-frame: invisible until the commit point
    update(10'd200, 10'd100, 3'd2, 1'b0, 1'b1, 10'd0, 10'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    px(10'd205, 10'd103, 1'b1, 4'd7, 4'd9, 4'd7, 1'b0);
    chk("spr_addr_pre_commit", {18'd0, spr_addr}, 32'd0);
    chk("ready_pre_commit", {31'd0, upd_ready}, 32'd0);
    // Second request while pending is ignored
    p1_x = 10'd50; upd_valid = 1'b1;
    px(10'd306, 10'd200, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
    px(10'd307, 10'd200, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
    chk("ready_hold_pend", {31'd0, upd_ready}, 32'd0);
    upd_valid = 1'b0;
    commit();
    px(10'd205, 10'd103, 1'b1, 4'd7, 4'd9, 4'd9, 1'b1);
    chk("spr_addr_205_103", {18'd0, spr_addr}, 32'd3173);
    px(10'd200, 10'd100, 1'b1, 4'd3, 4'd4, 4'd4, 1'b1);
    chk("spr_addr_corner_tl", {18'd0, spr_addr}, 32'd3072);
    px(10'd199, 10'd100, 1'b1, 4'd3, 4'd4, 4'd3, 1'b0);
    chk("spr_addr_left_miss", {18'd0, spr_addr}, 32'd0);
    px(10'd231, 10'd147, 1'b1, 4'd3, 4'd4, 4'd4, 1'b1);
    chk("spr_addr_corner_br", {18'd0, spr_addr}, 32'd4607);
    px(10'd232, 10'd100, 1'b1, 4'd2, 4'd4, 4'd2, 1'b0);
    chk("spr_addr_right_miss", {18'd0, spr_addr}, 32'd0);
    px(10'd200, 10'd148, 1'b1, 4'd2, 4'd4, 4'd2, 1'b0);
    chk("spr_addr_bottom_miss", {18'd0, spr_addr}, 32'd0);

    // Flip and transparency
    update(10'd200, 10'd100, 3'd2, 1'b1, 1'b1, 10'd0, 10'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    commit();
    px(10'd205, 10'd103, 1'b1, 4'd6, 4'd0, 4'd6, 1'b0);
    chk("spr_addr_flip", {18'd0, spr_addr}, 32'd3194);
    px(10'd205, 10'd103, 1'b1, 4'd6, 4'd12, 4'd12, 1'b1);

    // Overlap priority
    update(10'd200, 10'd100, 3'd2, 1'b0, 1'b1, 10'd204, 10'd100, 3'd5, 1'b0, 1'b1, 1'b1);
    commit();
    px(10'd205, 10'd103, 1'b1, 4'd1, 4'd11, 4'd11, 1'b1);
    chk("spr_addr_p2_top", {18'd0, spr_addr}, 32'd7777);
    px(10'd202, 10'd103, 1'b1, 4'd1, 4'd11, 4'd11, 1'b1);
    chk("spr_addr_p1_only", {18'd0, spr_addr}, 32'd3170);
    update(10'd200, 10'd100, 3'd2, 1'b0, 1'b1, 10'd204, 10'd100, 3'd5, 1'b0, 1'b1, 1'b0);
    commit();
    px(10'd205, 10'd103, 1'b1, 4'd1, 4'd11, 4'd11, 1'b1);
    chk("spr_addr_p1_top", {18'd0, spr_addr}, 32'd3173);
    update(10'd200, 10'd100, 3'd2, 1'b0, 1'b1, 10'd204, 10'd100, 3'd5, 1'b0, 1'b0, 1'b1);
    commit();
    px(10'd205, 10'd103, 1'b1, 4'd1, 4'd11, 4'd11, 1'b1);
    chk("spr_addr_p2_disabled", {18'd0, spr_addr}, 32'd3173);
    update(10'd200, 10'd100, 3'd2, 1'b0, 1'b0, 10'd204, 10'd100, 3'd5, 1'b0, 1'b0, 1'b1);
    commit();
    px(10'd205, 10'd103, 1'b1, 4'd4, 4'd11, 4'd4, 1'b0);
    chk("spr_addr_both_disabled", {18'd0, spr_addr}, 32'd0);

    // Sprite at the right edge: no wrap onto the left columns
    update(10'd1000, 10'd0, 3'd0, 1'b0, 1'b1, 10'd0, 10'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    commit();
    px(10'd1010, 10'd5, 1'b1, 4'd2, 4'd7, 4'd7, 1'b1);
    chk("spr_addr_x1000", {18'd0, spr_addr}, 32'd170);
    px(10'd5, 10'd5, 1'b1, 4'd2, 4'd7, 4'd2, 1'b0);
    chk("spr_addr_nowrap_5", {18'd0, spr_addr}, 32'd0);
    px(10'd20, 10'd5, 1'b1, 4'd2, 4'd7, 4'd2, 1'b0);
    chk("spr_addr_nowrap_20", {18'd0, spr_addr}, 32'd0);
    px(10'd1023, 10'd5, 1'b1, 4'd2, 4'd7, 4'd7, 1'b1);
    chk("spr_addr_x1023", {18'd0, spr_addr}, 32'd183);
    px(10'd999, 10'd5, 1'b1, 4'd2, 4'd7, 4'd2, 1'b0);
    chk("spr_addr_x999", {18'd0, spr_addr}, 32'd0);

    // Update accepted on the commit-point cycle commits one frame later
    px(10'd0, 10'd480, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
    set_players(10'd0, 10'd0, 3'd1, 1'b0, 1'b1, 10'd0, 10'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    upd_valid = 1'b1;
    chk("ready_on_commit_cycle", {31'd0, upd_ready}, 32'd1);
    px(10'd1, 10'd480, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
    upd_valid = 1'b0;
    chk("tick_same_cycle", {31'd0, frame_tick}, 32'd1);
    chk("ready_after_same_cycle", {31'd0, upd_ready}, 32'd0);
    px(10'd1010, 10'd5, 1'b1, 4'd2, 4'd7, 4'd7, 1'b1);
    chk("spr_addr_old_kept", {18'd0, spr_addr}, 32'd170);
    commit();
    px(10'd3, 10'd3, 1'b1, 4'd2, 4'd7, 4'd7, 1'b1);
    chk("spr_addr_next_frame", {18'd0, spr_addr}, 32'd1635);
    px(10'd1010, 10'd5, 1'b1, 4'd2, 4'd7, 4'd2, 1'b0);
    chk("spr_addr_old_gone", {18'd0, spr_addr}, 32'd0);

    // Reset while pending
    update(10'd0, 10'd0, 3'd3, 1'b0, 1'b1, 10'd0, 10'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    Reset = 1'b1;
    px(10'd11, 10'd10, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
    Reset = 1'b0;
    chk("ready_after_reset", {31'd0, upd_ready}, 32'd1);
    chk("tick_after_reset", {31'd0, frame_tick}, 32'd0);
    px(10'd3, 10'd3, 1'b1, 4'd2, 4'd7, 4'd2, 1'b0);
    chk("spr_addr_after_reset", {18'd0, spr_addr}, 32'd0);
    px(10'd4, 10'd3, 1'b1, 4'd2, 4'd7, 4'd2, 1'b0);
    chk("tick_idle_mid_frame", {31'd0, frame_tick}, 32'd0);
    commit();
    px(10'd3, 10'd3, 1'b1, 4'd2, 4'd7, 4'd2, 1'b0);
    chk("spr_addr_pending_dropped", {18'd0, spr_addr}, 32'd0);

    px(10'd0, 10'd0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
    px(10'd0, 10'd0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0);
    chk("scoreboard_drained", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
